// File: rtl/demux14_buf.sv
// Buffered 1-to-4 stream demultiplexer with an independent circular FIFO per channel.
// Optional saturating input-stall counter (stall_cnt) is built when DEMUX_STAT_EN is defined.
module demux14_buf #(
  parameter int DATA_LEN = 2,
  parameter int KEY_LEN  = 2,
  parameter int DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KEY_LEN-1:0]    in_key,
  input  logic [DATA_LEN-1:0]   in_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_LEN-1:0] out_data
`ifdef DEMUX_STAT_EN
  ,
  output logic [7:0]            stall_cnt
`endif
);

  localparam int NCH = 4;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;

  logic [DATA_LEN-1:0] mem_q [NCH][DEPTH];
  logic [PW-1:0]       wr_q  [NCH];
  logic [PW-1:0]       wr_d  [NCH];
  logic [PW-1:0]       rd_q  [NCH];
  logic [PW-1:0]       rd_d  [NCH];
  logic [CW-1:0]       cnt_q [NCH];
  logic [CW-1:0]       cnt_d [NCH];
  logic [NCH-1:0]      push;
  logic [NCH-1:0]      pop;
  logic [NCH-1:0]      nonempty;

  // Readiness looks only at the addressed channel's registered count, so a
  // simultaneous pop on a full channel grants no credit until the next cycle.
  always_comb begin
    in_ready  = (cnt_q[in_key] != CW'(DEPTH));
    out_data  = '0;
    out_valid = '0;
    push      = '0;
    pop       = '0;
    nonempty  = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      nonempty[n] = (cnt_q[n] != '0);
      push[n]     = in_valid && in_ready && (in_key == KEY_LEN'(n));
      pop[n]      = nonempty[n] && out_ready[n];
      out_valid[n] = nonempty[n];
      if (nonempty[n]) begin
        out_data[DATA_LEN*n +: DATA_LEN] = mem_q[n][rd_q[n]];
      end
      wr_d[n]  = wr_q[n] + PW'(push[n]);
      rd_d[n]  = rd_q[n] + PW'(pop[n]);
      cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        wr_q[n]  <= '0;
        rd_q[n]  <= '0;
        cnt_q[n] <= '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
          mem_q[n][e] <= '0;
        end
      end
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        wr_q[n]  <= wr_d[n];
        rd_q[n]  <= rd_d[n];
        cnt_q[n] <= cnt_d[n];
        if (push[n]) begin
          mem_q[n][wr_q[n]] <= in_data;
        end
      end
    end
  end

`ifdef DEMUX_STAT_EN
  logic [7:0] stall_q;
  logic [7:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux14_buf.sv
// Self-checking bench for demux14_buf: per-channel scoreboard queues plus scenario tasks.
module tb_demux14_buf;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_key;
  logic [1:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
`ifdef DEMUX_STAT_EN
  logic [7:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef logic [1:0] dq_t [$];
  dq_t sb [4];
  int  sz [4];

  demux14_buf #(.DATA_LEN(2), .KEY_LEN(2), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: accept/pop decisions are taken from the model's own occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 4; ch++) sb[ch].delete();
    end else begin
      for (int ch = 0; ch < 4; ch++) sz[ch] = sb[ch].size();
      for (int ch = 0; ch < 4; ch++) begin
        if (sz[ch] != 0 && out_ready[ch]) void'(sb[ch].pop_front());
      end
      if (in_valid && sz[in_key] != 2) sb[in_key].push_back(in_data);
    end
  end

  always @(negedge clk) begin
    logic       exp_v;
    logic [1:0] exp_d;
    logic       exp_r;
    #2;
    for (int ch = 0; ch < 4; ch++) begin
      exp_v = (sb[ch].size() != 0);
      exp_d = exp_v ? sb[ch][0] : 2'b00;
      checks++;
      if (out_valid[ch] !== exp_v) begin
        errors++;
        $display("FAIL sb_valid ch%0d t=%0t: got %b want %b", ch, $time, out_valid[ch], exp_v);
      end
      checks++;
      if (out_data[2*ch +: 2] !== exp_d) begin
        errors++;
        $display("FAIL sb_data ch%0d t=%0t: got %0d want %0d", ch, $time, out_data[2*ch +: 2], exp_d);
      end
    end
    exp_r = (sb[in_key].size() != 2);
    checks++;
    if (in_ready !== exp_r) begin
      errors++;
      $display("FAIL sb_ready key%0d t=%0t: got %b want %b", in_key, $time, in_ready, exp_r);
    end
  end

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL drain_empty: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h want 1 0000 00", in_ready, out_valid, out_data);
    end
`ifdef DEMUX_STAT_EN
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fanout();
    logic [3:0] exp_v;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = 2'(k);
      in_data  = 2'(3 - k);
      #1;
      exp_v = (k == 0) ? 4'b0000 : (4'b0001 << (k - 1));
      checks++;
      if (in_ready !== 1'b1 || out_valid !== exp_v) begin
        errors++;
        $display("FAIL fanout_k%0d: got rdy=%b v=%b want 1 %b", k, in_ready, out_valid, exp_v);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1000 || out_data[7:6] !== 2'd0) begin
      errors++;
      $display("FAIL fanout_last: got v=%b d=%h want 1000 ch3=0", out_valid, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL fanout_idle: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 4'b0000;
    in_key    = 2'd2;
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 2'(d);
    end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_third: got %b want 0", in_ready);
    end
    @(negedge clk);
    out_ready = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_data[5:4] !== 2'd1) begin
      errors++;
      $display("FAIL full_popcycle: got rdy=%b d=%0d want 0 1", in_ready, out_data[5:4]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[5:4] !== 2'd2) begin
      errors++;
      $display("FAIL full_credit: got rdy=%b d=%0d want 1 2", in_ready, out_data[5:4]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[5:4] !== 2'd3) begin
      errors++;
      $display("FAIL full_third_out: got v=%b d=%0d want 1 3", out_valid[2], out_data[5:4]);
    end
    drain();
  endtask

  task automatic test_isolation();
    out_ready = 4'b0000;
    for (int d = 1; d <= 2; d++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = 2'd1;
      in_data  = 2'(d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_key  = (i % 2 == 0) ? 2'd1 : 2'd0;
      in_data = 2'(i);
      #1;
      checks++;
      if (in_ready !== (in_key == 2'd0)) begin
        errors++;
        $display("FAIL iso_ready i%0d: got %b want %b", i, in_ready, (in_key == 2'd0));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data[1:0] !== 2'd1 || out_data[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL iso_heads: got ch0=%0d ch1=%0d want 1 1", out_data[1:0], out_data[3:2]);
    end
    drain();
  endtask

  task automatic test_wrap();
    out_ready = 4'b0000;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = 2'd3;
    in_data  = 2'd0;
    @(negedge clk);
    out_ready = 4'b1000;
    for (int i = 1; i <= 6; i++) begin
      in_data = 2'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 4'b1000 || out_data[7:6] !== 2'(i - 1)) begin
        errors++;
        $display("FAIL wrap_i%0d: got rdy=%b v=%b d=%0d want 1 1000 %0d",
                 i, in_ready, out_valid, out_data[7:6], 2'(i - 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data[7:6] !== 2'd2) begin
      errors++;
      $display("FAIL wrap_tail: got %0d want 2", out_data[7:6]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = (i < 2) ? 2'd0 : 2'd1;
      in_data  = 2'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_key   = 2'd0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got v=%b d=%h rdy=%b want 0000 00 1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_key   = 2'd0;
    in_data  = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0001 || out_data !== 8'h02) begin
      errors++;
      $display("FAIL midreset_first: got v=%b d=%h want 0001 02", out_valid, out_data);
    end
  endtask

`ifdef DEMUX_STAT_EN
  task automatic test_stall();
    out_ready = 4'b0000;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = 2'd0;
    in_data  = 2'd3;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stall_start: got rdy=%b cnt=%0d want 0 0", in_ready, stall_cnt);
    end
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      #1;
      if (i == 100 || i == 255 || i == 300) begin
        checks++;
        if (stall_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++;
          $display("FAIL stall_cnt_%0d: got %0d want %0d", i, stall_cnt, (i > 255) ? 255 : i);
        end
      end
    end
    drain();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_key    = 2'd0;
    in_data   = 2'd0;
    out_ready = 4'b0000;
    test_reset();
    test_fanout();
    test_full();
    test_isolation();
    test_wrap();
    test_reset_mid();
`ifdef DEMUX_STAT_EN
    test_stall();
`endif
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux14_buf.md
# demux14_buf

Buffered 1-to-4 stream demultiplexer: the distributing end of the 4-way key-select path. One 2-bit input stream carries a 2-bit key per beat, and the block routes each beat into one of four per-channel FIFOs, which drain independently over valid/ready. It sits between a single producer, such as a switch or keyboard decoder, and four independent consumers, such as LED or segment drivers.

## Interface
- DATA_LEN, 2, payload width per beat
- KEY_LEN, 2, key width; channel count fixed at 4 (2**KEY_LEN)
- DEPTH, 2, entries per channel FIFO; power of two, ≥2

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept the beat addressed by in_key
- in_key  in  KEY_LEN  destination channel of current beat
- in_data  in  DATA_LEN  payload
- out_valid  out  4  bit n: channel n FIFO non-empty
- out_ready  in  4  bit n: consumer n takes head beat
- out_data  out  4*DATA_LEN  channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
- stall_cnt  out  8  present only with DEMUX_STAT_EN (see Configuration)

## Operation
- Per channel n: DEPTH-entry circular FIFO with wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
- in_ready = (count[in_key] != DEPTH), combinational from in_key and registered count only; never depends on in_valid or out_ready.
- Push: in_valid && in_ready → write in_data at wr_ptr[in_key], increment wr_ptr and count of that channel only.
- Pop n: out_valid[n] && out_ready[n] → increment rd_ptr[n], decrement count[n]. Up to 4 pops per cycle, independent.
- Push and pop on same channel in same cycle: count unchanged, both pointers advance; legal at any non-full count.
- Full channel with simultaneous pop: in_ready stays 0 that cycle (no pass-through credit); the push completes the following cycle.
- out_valid[n] = (count[n] != 0); out_data slice n = entry at rd_ptr[n] when non-empty, all-zero when empty.
- A full channel stalls only beats keyed to it; beats to other channels are accepted in the same cycle.
- Input beat ordering is preserved within each channel; there is no ordering relation across channels.
- in_key/in_data may change while in_valid is high without acceptance. Producer is expected to hold them, but the block tolerates changes: it evaluates only the current key.

## Timing
- Reset (rst_n low, async assert, deassert sampled on clk): all pointers and counts 0, FIFO storage 0. During reset: out_valid=0, out_data=0, in_ready=1 (combinational, all empty), stall_cnt=0. No push or pop is taken while rst_n is low.
- Reset mid-operation discards all buffered beats immediately. Outputs drop to the reset values asynchronously.
- Latency: a beat accepted at edge k is visible on out_valid/out_data after edge k (first cycle after acceptance). There is no zero-cycle bypass.
- Throughput: 1 beat/cycle in; 1 beat/cycle per channel out.
- out_data/out_valid change only on clk edges or reset; they are stable while out_valid && !out_ready.

## Configuration
- DEMUX_STAT_EN defined: adds an 8-bit stall_cnt output register.
  - Increments each cycle where in_valid && !in_ready.
  - Saturates at 255.
  - Cleared only by reset.
- DEMUX_STAT_EN undefined: stall_cnt port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset, then out_ready=4'b1111; push key 0..3 with data 3,2,1,0 on consecutive cycles → each out_valid[n] pulses 1 cycle, one cycle after its push, with slice n = 3,2,1,0; in_ready constant 1.
- out_ready=0; push key 2 with data 1, 2, 3 → in_ready=0 on 3rd beat (DEPTH=2). Then out_ready[2]=1 → channel 2 yields 1 then 2; the 3rd beat is accepted one cycle after the first pop and emerges third.
- Channel 1 full, out_ready=0; alternate keys 1 and 0 → key-1 beats stall, key-0 beats accepted each cycle; channel 0 data order intact.
- Channel 3 holds 1 entry; push key 3 and pop channel 3 in the same cycle for 6 cycles → count stays 1, data emerges in order, pointers wrap without loss.
- Fill channels 0 and 1, assert rst_n=0 mid-cycle for 1 cycle → out_valid=0 and out_data=0 immediately; after release the first push to key 0 emerges alone.
- DEMUX_STAT_EN: hold in_valid=1 to a full channel for 300 cycles → stall_cnt reads 255, not wrapping to 44.
